clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 119 +++++++++++
 tb/tb_clk_div_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with start/stop control and ratio handshake
// Optional feature macro CLKDIV_TICK_CNT_EN adds a 16-bit wrapping tick counter output.
module clk_div_ctrl #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         div_req,
  input  logic [W-1:0] div_val,
  output logic         div_ack,
  output logic         div_err,
  output logic         q,
  output logic         tick,
`ifdef CLKDIV_TICK_CNT_EN
  output logic [15:0]  tick_cnt,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   ratio_q, ratio_d;
  logic [W-1:0]   pend_val_q, pend_val_d;
  logic           pend_q, pend_d;
  logic           q_q, q_d;
  logic           tick_q, tick_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic           last;
  logic           apply;
  logic           capture;

  // Last cycle of the current period; ratio >= 2 so the subtraction never wraps.
  assign last = (cnt_q == ratio_q - W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start && !stop) state_d = RUN;
      RUN:      if (stop) state_d = last ? IDLE : STOPPING;
      STOPPING: begin
        if (start)     state_d = RUN;
        else if (last) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    apply      = pend_q && ((state_q == IDLE) || last);
    capture    = div_req && (div_val >= W'(2)) && !pend_q;
    ratio_d    = apply ? pend_val_q : ratio_q;
    pend_d     = capture | (pend_q & ~apply);
    pend_val_d = capture ? div_val : pend_val_q;
    err_d      = div_req && (div_val < W'(2));
    ack_d      = apply;

    if ((state_d == IDLE) || (state_q == IDLE) || last) cnt_d = '0;
    else                                                cnt_d = cnt_q + W'(1);

    // Outputs are registered from the next count so q/tick line up with cnt.
    q_d    = (state_d != IDLE) && (cnt_d < (ratio_d >> 1));
    tick_d = (state_d != IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ratio_q    <= W'(DEF_DIV);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      q_q        <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      q_q        <= q_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign q       = q_q;
  assign tick    = tick_q;
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign busy    = (state_q != IDLE);

`ifdef CLKDIV_TICK_CNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q + {15'd0, tick_q};
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= 16'd0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
// Table vectors, directed corner sequences and random stimulus against a period-timing model.
module tb_clk_div_ctrl;

  localparam int W       = 8;
  localparam int DEF_DIV = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         div_req = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_ack, div_err, q, tick, busy;
`ifdef CLKDIV_TICK_CNT_EN
  logic [15:0]  tick_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .q       (q),
    .tick    (tick),
`ifdef CLKDIV_TICK_CNT_EN
    .tick_cnt(tick_cnt),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Model: timing derived from the cycle index at which the current period began.
  int m_t, m_ps, m_n, m_pend_val;
  bit m_active, m_stopping, m_pend;
  bit m_q, m_tick, m_busy, m_ack, m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit at_end, apply, cap;
    int new_n;
    if (rst) begin
      m_active = 0; m_stopping = 0; m_pend = 0; m_pend_val = 0;
      m_n = DEF_DIV; m_t = 0; m_ps = 0;
      m_q = 0; m_tick = 0; m_busy = 0; m_ack = 0; m_err = 0;
    end else begin
      at_end = m_active && ((m_t - m_ps) == m_n - 1);
      apply  = m_pend && (!m_active || at_end);
      cap    = div_req && (int'(div_val) >= 2) && !m_pend;
      m_err  = div_req && (int'(div_val) < 2);
      m_ack  = apply;
      new_n  = apply ? m_pend_val : m_n;
      if (apply) m_pend = 0;
      if (cap) begin m_pend = 1; m_pend_val = int'(div_val); end
      if (!m_active) begin
        if (start && !stop) begin m_active = 1; m_stopping = 0; m_ps = m_t + 1; end
      end else if (m_stopping) begin
        if (start) m_stopping = 0;
        else if (at_end) m_active = 0;
      end else if (stop) begin
        if (at_end) m_active = 0;
        else m_stopping = 1;
      end
      if (m_active && at_end) m_ps = m_t + 1;
      m_n = new_n;
      m_t++;
      m_q    = m_active && ((m_t - m_ps) < m_n / 2);
      m_tick = m_active && ((m_t - m_ps) == 0);
      m_busy = m_active;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic dr,
                      input logic [W-1:0] dv, input bit use_model);
    rst = r; start = s; stop = p; div_req = dr; div_val = dv;
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (use_model) begin
      chk("q", int'(q), int'(m_q));
      chk("tick", int'(tick), int'(m_tick));
      chk("busy", int'(busy), int'(m_busy));
      chk("div_ack", int'(div_ack), int'(m_ack));
      chk("div_err", int'(div_err), int'(m_err));
    end
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0, '0, 1);
      n++;
    end while (!tick && n < 300);
  endtask

  typedef struct packed {
    logic r, s, p, dr;
    logic [7:0] dv;
    logic eq, et, eb, ea, ee;
  } vec_t;

  vec_t vecs [0:17];

  initial begin
    int n;
    // {rst,start,stop,div_req,div_val, q,tick,busy,ack,err}
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,8'd1, 1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'd0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,8'd5, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b1,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,8'd0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b1,1'b1,1'b0,1'b0};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].dr, vecs[i].dv, 0);
      chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].eq));
      chk($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].et));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eb));
      chk($sformatf("vec%0d_ack", i), int'(div_ack), int'(vecs[i].ea));
      chk($sformatf("vec%0d_err", i), int'(div_err), int'(vecs[i].ee));
    end

    // Ratio change mid-period: N=4, request 7 while cnt=1.
    step(1, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 1, 8'd4, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 1, 8'd7, 1);
    run_to_tick(n);
    chk("chg_gap_old", n, 2);
    chk("chg_ack_with_tick", int'(div_ack), 1);
    run_to_tick(n);
    chk("chg_period_new", n, 7);

    // Stop at cnt=2 of N=6, then stop followed by restart while stopping.
    step(1, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 1, 8'd6, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 1, 0, 8'd0, 1);
    n = 0;
    while (busy && n < 20) begin
      step(0, 0, 0, 0, 8'd0, 1);
      n++;
    end
    chk("stop_drain_cycles", n, 3);
    chk("stop_q_low", int'(q), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 8'd0, 1);
      chk("stop_no_tick", int'(tick), 0);
    end
    step(0, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 1, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    chk("resume_tick", int'(tick), 1);
    chk("resume_busy", int'(busy), 1);

    // Second request while one is pending is dropped.
    step(0, 0, 0, 1, 8'd3, 1);
    step(0, 0, 0, 1, 8'd9, 1);
    run_to_tick(n);
    chk("pend_gap", n, 4);
    chk("pend_ack", int'(div_ack), 1);
    run_to_tick(n);
    chk("pend_first_kept", n, 3);

    // Reset at cnt=3 of N=8 with a request pending.
    step(1, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 1, 8'd8, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 1, 8'd5, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(1, 0, 0, 0, 8'd0, 1);
    chk("rst_q", int'(q), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(div_ack), 0);
    step(0, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);
    chk("rst_def_div_tick", int'(tick), 1);

    // Maximum ratio: one full period without counter overflow.
    step(0, 0, 0, 1, 8'd255, 1);
    run_to_tick(n);
    run_to_tick(n);
    chk("max_ratio_period", n, 255);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] dv;
      dv = ($urandom_range(0, 19) == 0) ? W'($urandom_range(200, 255)) : W'($urandom_range(0, 12));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), dv, 1);
    end

`ifdef CLKDIV_TICK_CNT_EN
    step(1, 0, 0, 0, 8'd0, 0);
    chk("tcnt_reset", int'(tick_cnt), 0);
    step(0, 1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 131071; i++) step(0, 0, 0, 0, 8'd0, 0);
    step(0, 0, 1, 0, 8'd0, 0);
    step(0, 0, 0, 0, 8'd0, 0);
    chk("tcnt_wrap", int'(tick_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
